barrier_gen: RTL and testbench

Parametrised successor to the fixed barrier lookup: generates lane-barrier rows procedurally from an LFSR instead of a hard-coded table. Keeps a scrolling window of the next DEPTH rows for the renderer, advances one row per `step`, and checks the row entering the player row against the player lane. Sits between the game-tick divider and the VGA/LED renderer plus game-control logic.

---
 rtl/barrier_pkg.sv | 19 +
 rtl/barrier_lfsr.sv | 37 +++
 rtl/barrier_gen.sv | 139 +++++++++++++
 tb/tb_barrier_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrier_pkg.sv
// Shared types and constants for the procedural lane-barrier generator.
package barrier_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] SCORE_MAX    = 16'hFFFF;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/barrier_lfsr.sv
// 16-bit Galois LFSR with synchronous load; a zero load value is replaced by the default seed.
module barrier_lfsr
  import barrier_pkg::*;
#(
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [15:0]      load_val_i,
  input  logic             adv_i,
  output logic [OUT_W-1:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      // An all-zero state would lock up the register forever.
      lfsr_d = (load_val_i == 16'h0000) ? LFSR_DEFAULT : load_val_i;
    end else if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/barrier_gen.sv
// Scrolling barrier window: procedurally generates rows, scrolls on step, detects player collisions.
module barrier_gen
  import barrier_pkg::*;
#(
  parameter int unsigned LANES   = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WARMUP  = 10,
  parameter int unsigned GAP_MIN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [15:0]            seed_i,
  input  logic [1:0]             level_i,
  input  logic                   step_i,
  input  logic [LANES-1:0]       player_lane_i,
  output logic [LANES*DEPTH-1:0] grid_o,
  output logic                   hit_o,
  output logic                   game_over_o,
  output logic [15:0]            score_o,
  output logic [1:0]             state_o
);

  localparam int unsigned PtrW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned GridW = LANES * DEPTH;

  state_e             state_q, state_d;
  logic [GridW-1:0]   grid_q, grid_d;
  logic [15:0]        score_q, score_d;
  logic [15:0]        warm_q, warm_d;
  logic [7:0]         gap_q, gap_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               hit_q, hit_d;
  logic               over_q, over_d;

  logic               lfsr_load, lfsr_adv;
  logic [LANES-1:0]   cand;
  logic [LANES-1:0]   new_row;
  logic [LANES-1:0]   row1;
  logic [7:0]         gap_load;

  barrier_lfsr #(
    .OUT_W(LANES)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i (seed_i),
    .adv_i      (lfsr_adv),
    .value_o    (cand)
  );

  assign row1     = grid_q[LANES +: LANES];
  assign gap_load = 8'(GAP_MIN) + {6'd0, 2'd3 - level_i};

  // Row that enters at the top of the window on an accepted step.
  always_comb begin
    new_row = '0;
    if (warm_q == 16'd0 && gap_q == 8'd0) begin
      new_row = cand;
      if (cand == {LANES{1'b1}}) begin
        new_row[ptr_q] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    score_d   = score_q;
    warm_d    = warm_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    hit_d     = 1'b0;
    over_d    = over_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    if (start_i) begin
      lfsr_load = 1'b1;
      grid_d    = '0;
      score_d   = 16'd0;
      warm_d    = 16'(WARMUP);
      gap_d     = 8'd0;
      over_d    = 1'b0;
      state_d   = StRun;
    end else if (step_i && state_q == StRun) begin
      lfsr_adv = 1'b1;
      ptr_d    = (ptr_q == PtrW'(LANES - 1)) ? '0 : ptr_q + 1'b1;
      grid_d   = {new_row, grid_q[GridW-1:LANES]};

      if (warm_q != 16'd0) begin
        warm_d = warm_q - 16'd1;
      end else if (gap_q != 8'd0) begin
        gap_d = gap_q - 8'd1;
      end else if (new_row != '0) begin
        gap_d = gap_load;
      end

      // Collision is judged on the row about to slide into the player row.
      if ((row1 & player_lane_i) != '0) begin
        hit_d   = 1'b1;
        over_d  = 1'b1;
        state_d = StOver;
      end else if (row1 != '0 && score_q != SCORE_MAX) begin
        score_d = score_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grid_q  <= '0;
      score_q <= 16'd0;
      warm_q  <= 16'd0;
      gap_q   <= 8'd0;
      ptr_q   <= '0;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      score_q <= score_d;
      warm_q  <= warm_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      hit_q   <= hit_d;
      over_q  <= over_d;
    end
  end

  assign grid_o      = grid_q;
  assign hit_o       = hit_q;
  assign game_over_o = over_q;
  assign score_o     = score_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_barrier_gen.sv
// Randomised bench for barrier_gen against a row-list reference model.
module tb_barrier_gen;

  localparam int unsigned LANES   = 3;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned WARMUP  = 10;
  localparam int unsigned GAP_MIN = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [15:0]            seed = 16'd0;
  logic [1:0]             level = 2'd3;
  logic                   step = 1'b0;
  logic [LANES-1:0]       player = 3'b001;
  logic [LANES*DEPTH-1:0] grid;
  logic                   hit;
  logic                   game_over;
  logic [15:0]            score;
  logic [1:0]             state;

  int passed = 0;
  int total  = 0;

  // Reference model: window as a list of rows, counters as plain integers.
  logic [LANES-1:0] m_rows[DEPTH];
  logic [15:0]      m_lfsr;
  int               m_warm, m_gap, m_ptr, m_score, m_state;
  bit               m_hit;

  barrier_gen #(
    .LANES   (LANES),
    .DEPTH   (DEPTH),
    .WARMUP  (WARMUP),
    .GAP_MIN (GAP_MIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .seed_i        (seed),
    .level_i       (level),
    .step_i        (step),
    .player_lane_i (player),
    .grid_o        (grid),
    .hit_o         (hit),
    .game_over_o   (game_over),
    .score_o       (score),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  function automatic logic [LANES*DEPTH-1:0] m_grid();
    logic [LANES*DEPTH-1:0] g = '0;
    for (int r = 0; r < DEPTH; r++) g[r*LANES +: LANES] = m_rows[r];
    return g;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < DEPTH; r++) m_rows[r] = '0;
    m_lfsr = 16'hACE1; m_warm = 0; m_gap = 0; m_ptr = 0;
    m_score = 0; m_state = 0; m_hit = 0;
  endtask

  task automatic m_start(input logic [15:0] sd);
    for (int r = 0; r < DEPTH; r++) m_rows[r] = '0;
    m_lfsr = (sd == 16'd0) ? 16'hACE1 : sd;
    m_score = 0; m_warm = WARMUP; m_gap = 0; m_state = 1;
  endtask

  task automatic m_step(input logic [LANES-1:0] pl, input logic [1:0] lvl);
    logic [LANES-1:0] nr;
    logic [LANES-1:0] r1;
    r1 = m_rows[1];
    nr = '0;
    if (m_warm > 0) m_warm--;
    else if (m_gap > 0) m_gap--;
    else begin
      nr = m_lfsr[LANES-1:0];
      if (nr == {LANES{1'b1}}) nr[m_ptr] = 1'b0;
      if (nr != 0) m_gap = GAP_MIN + 3 - int'(lvl);
    end
    m_ptr = (m_ptr + 1) % LANES;
    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
    for (int r = 0; r < DEPTH - 1; r++) m_rows[r] = m_rows[r+1];
    m_rows[DEPTH-1] = nr;
    if ((r1 & pl) != 0) begin
      m_hit = 1; m_state = 2;
    end else if (r1 != 0 && m_score < 65535) begin
      m_score++;
    end
  endtask

  function automatic logic [LANES-1:0] safe_lane(input logic [LANES-1:0] row);
    int s = $urandom_range(LANES - 1);
    for (int k = 0; k < LANES; k++) begin
      int i = (s + k) % LANES;
      if (!row[i]) return LANES'(1) << i;
    end
    return LANES'(1);
  endfunction

  task automatic tick(input bit st, input logic [15:0] sd, input bit sp,
                      input logic [LANES-1:0] pl);
    start = st; seed = sd; step = sp; player = pl;
    @(posedge clk);
    m_hit = 0;
    if (st) m_start(sd);
    else if (sp && m_state == 1) m_step(pl, level);
    #1;
    start = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({grid, hit, game_over, score, state} !== '0) begin
      $display("FAIL reset: grid=%h hit=%b over=%b score=%h state=%0d, want all zero",
               grid, hit, game_over, score, state);
    end else passed++;
    tick(0, 16'd0, 1, 3'b001);
    total++;
    if (grid !== '0 || state !== 2'd0) begin
      $display("FAIL idle_step: grid=%h state=%0d, want 0/0", grid, state);
    end else passed++;
  endtask

  task automatic test_warmup();
    level = 2'd3;
    tick(1, 16'd0, 0, 3'b001);
    total++;
    if (state !== 2'd1 || grid !== '0 || score !== 16'd0) begin
      $display("FAIL start_seed0: state=%0d grid=%h score=%h, want 1/0/0", state, grid, score);
    end else passed++;
    for (int i = 0; i < WARMUP; i++) begin
      tick(0, 16'd0, 1, 3'b001);
      total++;
      if (grid !== '0) $display("FAIL warmup_row%0d: grid=%h, want 0", i, grid);
      else passed++;
    end
    // First generated row comes from the substituted default seed.
    for (int i = 0; i < 6; i++) begin
      tick(0, 16'd0, 1, safe_lane(m_rows[1]));
      total++;
      if (grid !== m_grid() || score !== 16'(m_score)) begin
        $display("FAIL seed0_rows%0d: grid=%h score=%h, want grid=%h score=%h",
                 i, grid, score, m_grid(), 16'(m_score));
      end else passed++;
    end
  endtask

  task automatic test_random(input logic [1:0] lvl, input int n);
    level = lvl;
    tick(1, 16'($urandom), 0, 3'b001);
    for (int i = 0; i < n; i++) begin
      logic [LANES-1:0] pl;
      bit st;
      pl = ($urandom_range(19) == 0) ? LANES'($urandom) : safe_lane(m_rows[1]);
      st = (m_state == 2 && $urandom_range(3) == 0) || ($urandom_range(199) == 0);
      tick(st, 16'($urandom), $urandom_range(9) < 7, pl);
      total++;
      if (grid !== m_grid()) $display("FAIL rand_grid L%0d #%0d: grid=%h, want %h",
                                      lvl, i, grid, m_grid());
      else passed++;
      total++;
      if (score !== 16'(m_score) || state !== 2'(m_state) || hit !== m_hit ||
          game_over !== (m_state == 2)) begin
        $display("FAIL rand_ctrl L%0d #%0d: score=%h state=%0d hit=%b over=%b, want %h/%0d/%b/%b",
                 lvl, i, score, state, hit, game_over, 16'(m_score), m_state, m_hit,
                 m_state == 2);
      end else passed++;
    end
  endtask

  task automatic test_gap(input logic [1:0] lvl);
    int zeros = 0;
    bit seen = 0;
    logic [LANES-1:0] top;
    level = lvl;
    tick(1, 16'($urandom), 0, 3'b001);
    for (int i = 0; i < 120; i++) begin
      tick(0, 16'd0, 1, safe_lane(m_rows[1]));
      top = grid[(DEPTH-1)*LANES +: LANES];
      if (top != 0) begin
        if (seen) begin
          total++;
          if (zeros < GAP_MIN + 3 - int'(lvl))
            $display("FAIL gap L%0d: %0d empty rows, want >= %0d", lvl, zeros,
                     GAP_MIN + 3 - int'(lvl));
          else passed++;
        end
        seen = 1; zeros = 0;
      end else zeros++;
    end
    total++;
    if (grid !== m_grid()) $display("FAIL gap_grid L%0d: grid=%h, want %h", lvl, grid, m_grid());
    else passed++;
  endtask

  task automatic test_score_and_over();
    logic [LANES*DEPTH-1:0] frozen;
    int prev;
    int guard = 0;
    level = 2'd2;
    tick(1, 16'($urandom), 0, 3'b001);
    while (m_rows[1] == 0 && guard < 200) begin
      tick(0, 16'd0, 1, safe_lane(m_rows[1])); guard++;
    end
    prev = m_score;
    tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    total++;
    if (score !== 16'(prev + 1)) $display("FAIL score_inc: score=%h, want %h", score, 16'(prev + 1));
    else passed++;
    guard = 0;
    while (m_rows[1] == 0 && guard < 200) begin
      tick(0, 16'd0, 1, safe_lane(m_rows[1])); guard++;
    end
    prev = m_score;
    tick(0, 16'd0, 1, m_rows[1]);
    total++;
    if (hit !== 1'b1 || state !== 2'd2 || game_over !== 1'b1 || score !== 16'(prev)) begin
      $display("FAIL hit: hit=%b state=%0d over=%b score=%h, want 1/2/1/%h",
               hit, state, game_over, score, 16'(prev));
    end else passed++;
    frozen = grid;
    tick(0, 16'd0, 0, 3'b001);
    total++;
    if (hit !== 1'b0) $display("FAIL hit_pulse: hit=%b, want 0", hit);
    else passed++;
    for (int i = 0; i < 3; i++) tick(0, 16'd0, 1, 3'b000);
    total++;
    if (grid !== frozen || state !== 2'd2) begin
      $display("FAIL over_frozen: grid=%h state=%0d, want %h/2", grid, state, frozen);
    end else passed++;
    tick(1, 16'($urandom), 0, 3'b001);
    total++;
    if (state !== 2'd1 || grid !== '0 || score !== 16'd0 || game_over !== 1'b0) begin
      $display("FAIL restart: state=%0d grid=%h score=%h over=%b, want 1/0/0/0",
               state, grid, score, game_over);
    end else passed++;
  endtask

  task automatic test_start_step();
    level = 2'd1;
    tick(1, 16'($urandom), 0, 3'b001);
    for (int i = 0; i < WARMUP + 8; i++) tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    tick(1, 16'h1234, 1, 3'b111);
    total++;
    if (grid !== '0 || state !== 2'd1 || score !== 16'd0 || hit !== 1'b0) begin
      $display("FAIL start_step: grid=%h state=%0d score=%h hit=%b, want 0/1/0/0",
               grid, state, score, hit);
    end else passed++;
    for (int i = 0; i < WARMUP + 4; i++) tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    total++;
    if (grid !== m_grid()) $display("FAIL start_step_rows: grid=%h, want %h", grid, m_grid());
    else passed++;
  endtask

  task automatic test_saturate();
    int guard = 0;
    level = 2'd3;
    tick(1, 16'($urandom), 0, 3'b001);
    for (int i = 0; i < WARMUP; i++) tick(0, 16'd0, 1, 3'b001);
    force dut.score_q = 16'hFFFF;
    #1 release dut.score_q;
    m_score = 65535;
    while (m_rows[1] == 0 && guard < 200) begin
      tick(0, 16'd0, 1, safe_lane(m_rows[1])); guard++;
    end
    tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    total++;
    if (score !== 16'hFFFF || state !== 2'd1) begin
      $display("FAIL saturate: score=%h state=%0d, want FFFF/1", score, state);
    end else passed++;
  endtask

  task automatic test_async_reset();
    level = 2'd0;
    tick(1, 16'($urandom), 0, 3'b001);
    for (int i = 0; i < WARMUP + 6; i++) tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    rst_n = 1'b0;
    m_reset();
    #2;
    total++;
    if ({grid, hit, game_over, score, state} !== '0) begin
      $display("FAIL async_reset: grid=%h hit=%b over=%b score=%h state=%0d, want all zero",
               grid, hit, game_over, score, state);
    end else passed++;
    #1 rst_n = 1'b1;
    tick(1, 16'd0, 0, 3'b001);
    for (int i = 0; i < WARMUP + 10; i++) tick(0, 16'd0, 1, safe_lane(m_rows[1]));
    total++;
    if (grid !== m_grid()) $display("FAIL post_reset_rows: grid=%h, want %h", grid, m_grid());
    else passed++;
  endtask

  initial begin
    m_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_warmup();
    for (int l = 0; l < 4; l++) test_random(2'(l), 400);
    test_gap(2'd3);
    test_gap(2'd0);
    test_score_and_over();
    test_start_step();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
